// File: rtl/pipo_load_arbiter.sv
// One-entry shared holding register fed by NREQ requesters through a round-robin arbiter,
// drained by a single consumer over a valid/ack handshake.
module pipo_load_arbiter #(
    parameter int WIDTH = 4,
    parameter int NREQ  = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NREQ-1:0]             req,
    input  logic [NREQ*WIDTH-1:0]       din,
    output logic [NREQ-1:0]             gnt,
    output logic [WIDTH-1:0]            Q,
    output logic                        q_valid,
    output logic [$clog2(NREQ)-1:0]     q_src,
    input  logic                        q_ack
);

    localparam int SRCW = $clog2(NREQ);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t            state_reg, state_next;
    logic [WIDTH-1:0]  q_reg, q_next;
    logic [SRCW-1:0]   src_reg, src_next;
    logic [SRCW-1:0]   last_gnt_reg, last_gnt_next;

    logic [WIDTH-1:0]  slice [NREQ];
    logic              load_ok;
    logic              grant_any;
    logic [SRCW-1:0]   winner;
    logic [NREQ-1:0]   gnt_vec;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
        assign slice[gi] = din[gi*WIDTH +: WIDTH];
    end

    // The register can accept a word when empty, or when the held word leaves this cycle.
    assign load_ok = (state_reg == EMPTY) | q_ack;

    // Rotating scan starting just after the last winner; the first asserted request wins.
    always_comb begin
        logic [SRCW:0] sum;
        grant_any = 1'b0;
        winner    = '0;
        gnt_vec   = '0;
        sum       = '0;
        if (load_ok && !rst) begin
            for (int k = 1; k <= NREQ; k++) begin
                sum = {1'b0, last_gnt_reg} + (SRCW+1)'(k);
                if (sum >= (SRCW+1)'(NREQ)) begin
                    sum = sum - (SRCW+1)'(NREQ);
                end
                if (!grant_any && req[sum[SRCW-1:0]]) begin
                    grant_any = 1'b1;
                    winner    = sum[SRCW-1:0];
                end
            end
        end
        if (grant_any) begin
            gnt_vec[winner] = 1'b1;
        end
    end

    always_comb begin
        state_next    = state_reg;
        q_next        = q_reg;
        src_next      = src_reg;
        last_gnt_next = last_gnt_reg;
        if (grant_any) begin
            state_next    = FULL;
            q_next        = slice[winner];
            src_next      = winner;
            last_gnt_next = winner;
        end else if (state_reg == FULL && q_ack) begin
            // Consumed with nothing to replace it; Q keeps its last value.
            state_next = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= EMPTY;
            q_reg        <= '0;
            src_reg      <= '0;
            last_gnt_reg <= SRCW'(NREQ-1);
        end else begin
            state_reg    <= state_next;
            q_reg        <= q_next;
            src_reg      <= src_next;
            last_gnt_reg <= last_gnt_next;
        end
    end

    assign gnt     = gnt_vec;
    assign Q       = q_reg;
    assign q_valid = (state_reg == FULL);
    assign q_src   = src_reg;

endmodule
